// File: rtl/am_demod.sv
// am_demod: AM/ASK demodulator (rectify, window peak, DC removal, hysteresis slicer); define AM_DEMOD_AVG_EN for window-mean envelope
module am_demod #(
  parameter int DW        = 14,
  parameter int WIN_LOG2  = 6,
  parameter int DC_SHIFT  = 4,
  parameter int THRESH_HI = 2048,
  parameter int THRESH_LO = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 env_valid,
  output logic [DW-1:0]        env,
  output logic                 mod_valid,
  output logic signed [DW-1:0] mod_out,
  output logic                 bit_out,
  output logic                 bit_edge
);
  localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] TH_HI = DW'(THRESH_HI);
  localparam logic [DW-1:0] TH_LO = DW'(THRESH_LO);
  typedef enum logic {LOW, HIGH} state_t;
  state_t state, state_n;
  logic v1, last;
  logic [DW-1:0] abs1, abs_c, env_c;
  logic [WIN_LOG2-1:0] cnt;
  logic [DW+DC_SHIFT-1:0] dc;
  logic signed [DW:0] diff;
  logic signed [DW-1:0] mod_c;
  logic signed [DW+DC_SHIFT+1:0] delta, dsh;
  assign abs_c = (din == MINN) ? MAXP : din[DW-1] ? -din : din;
  assign last = v1 && (cnt == '1);
`ifdef AM_DEMOD_AVG_EN
  logic [DW+WIN_LOG2-1:0] acc, sum;
  assign sum = acc + (DW+WIN_LOG2)'(abs1);
  assign env_c = sum[DW+WIN_LOG2-1:WIN_LOG2];
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (v1) acc <= last ? '0 : sum;
`else
  logic [DW-1:0] peak;
  assign env_c = (abs1 > peak) ? abs1 : peak;
  always_ff @(posedge clk or posedge rst)
    if (rst) peak <= '0;
    else if (v1) peak <= last ? '0 : env_c;
`endif
  // DC estimate holds DC_SHIFT fraction bits; only its integer part is subtracted
  assign diff  = $signed({1'b0, env}) - $signed({1'b0, dc[DW+DC_SHIFT-1:DC_SHIFT]});
  assign mod_c = (diff[DW] != diff[DW-1]) ? (diff[DW] ? MINN : MAXP) : diff[DW-1:0];
  assign delta = $signed({2'b0, env, {DC_SHIFT{1'b0}}}) - $signed({2'b0, dc});
  assign dsh   = delta >>> DC_SHIFT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1        <= 1'b0;
      abs1      <= '0;
      cnt       <= '0;
      env_valid <= 1'b0;
      env       <= '0;
      mod_valid <= 1'b0;
      mod_out   <= '0;
      dc        <= '0;
    end else begin
      v1        <= din_valid;
      env_valid <= last;
      mod_valid <= env_valid;
      if (din_valid) abs1 <= abs_c;
      if (v1) cnt <= cnt + 1'b1;
      if (last) env <= env_c;
      if (env_valid) begin
        mod_out <= mod_c;
        dc      <= dc + dsh[DW+DC_SHIFT-1:0];
      end
    end
  always_comb
    state_n = !env_valid ? state :
              (state == LOW && env >= TH_HI) ? HIGH :
              (state == HIGH && env <= TH_LO) ? LOW : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= LOW;
      bit_edge <= 1'b0;
    end else begin
      state    <= state_n;
      bit_edge <= state_n != state;
    end
  assign bit_out = (state == HIGH);
endmodule

// File: tb/tb_am_demod.sv
// tb_am_demod: directed self-checking bench for am_demod (default peak-envelope build)
module tb_am_demod;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0;
  logic signed [13:0] din = '0;
  logic env_valid, mod_valid, bit_out, bit_edge;
  logic [13:0] env;
  logic signed [13:0] mod_out;
  int checks = 0, errors = 0, ev_cnt = 0, dc_fx = 0, mod_seen = 0;
  int pk[6]   = '{500, 3000, 2500, 1500, 800, 1024};
  int bits[6] = '{0, 1, 1, 1, 0, 0};
  int edgs[6] = '{0, 1, 0, 0, 1, 0};
  am_demod dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .env_valid(env_valid), .env(env), .mod_valid(mod_valid), .mod_out(mod_out),
    .bit_out(bit_out), .bit_edge(bit_edge)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (env_valid) ev_cnt++;
  end
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_env"}, int'(env), 0);
    chk({tag, "_envv"}, int'(env_valid), 0);
    chk({tag, "_mod"}, int'(mod_out), 0);
    chk({tag, "_modv"}, int'(mod_valid), 0);
    chk({tag, "_bit"}, int'(bit_out), 0);
    chk({tag, "_edge"}, int'(bit_edge), 0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc_fx = 0;
  endtask
  // pos < 0: alternate a (even) / b (odd); otherwise sample pos is b, rest a
  task automatic window(string tag, int a, int b, int pos, int gap, int exp_env, int exp_bit, int exp_edge);
    int e0 = ev_cnt;
    int m;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      din = 14'((pos < 0) ? ((i % 2) ? b : a) : ((i == pos) ? b : a));
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_envv"}, int'(env_valid), 1);
    chk({tag, "_env"}, int'(env), exp_env);
    chk({tag, "_npulse"}, ev_cnt - e0, 1);
    m = exp_env - (dc_fx >>> 4);
    dc_fx = dc_fx + (((exp_env <<< 4) - dc_fx) >>> 4);
    @(negedge clk);
    mod_seen = int'(mod_out);
    chk({tag, "_envv_off"}, int'(env_valid), 0);
    chk({tag, "_modv"}, int'(mod_valid), 1);
    chk({tag, "_mod"}, mod_seen, m);
    chk({tag, "_bit"}, int'(bit_out), exp_bit);
    chk({tag, "_edge"}, int'(bit_edge), exp_edge);
    @(negedge clk);
    chk({tag, "_modv_off"}, int'(mod_valid), 0);
    chk({tag, "_edge_off"}, int'(bit_edge), 0);
  endtask
  initial begin
    #1;
    chk_zero("rst0");
    do_reset();
    chk_zero("rst1");
    window("const1000", 1000, 1000, -1, 0, 1000, 0, 0);
    window("alt1000", 1000, -1000, -1, 0, 1000, 0, 0);
    window("sat", 0, -8192, 17, 0, 8191, 1, 1);
    do_reset();
    for (int k = 0; k < 6; k++)
      window($sformatf("slice%0d", k), 0, pk[k], 5 + k, 0, pk[k], bits[k], edgs[k]);
    do_reset();
    window("dc1", 4096, 4096, -1, 0, 4096, 1, 1);
    chk("dc1_hand", mod_seen, 4096);
    window("dc2", 4096, 4096, -1, 0, 4096, 1, 0);
    chk("dc2_hand", mod_seen, 3840);
    window("dc3", 4096, 4096, -1, 0, 4096, 1, 0);
    chk("dc3_hand", mod_seen, 3600);
    for (int i = 0; i < 30; i++) begin
      din = 14'sd5000;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    dc_fx = 0;
    window("post_rst", 300, 300, -1, 0, 300, 0, 0);
    window("gap", 700, 700, -1, 2, 700, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
